// File: rtl/microc_pkg.sv
// Shared constants for the multicycle microcontroller control unit:
// FSM state encoding, special opcodes and the control-word layout.
package microc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [5:0] OP_LI   = 6'b100000;
   localparam logic [5:0] OP_J    = 6'b101000;
   localparam logic [5:0] OP_JZ   = 6'b101001;
   localparam logic [5:0] OP_JNZ  = 6'b101010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic       wez;
      logic [2:0] alu_op;
      logic       pc_en;
   } ctrl_t;

   // Quiescent controls: PC+1 selected but not loaded, no writes.
   localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0,
                                   alu_op: 3'b000, pc_en: 1'b0};

endpackage

// File: rtl/uc_decode.sv
// Combinational decoder: latched IR plus live zero flag to datapath controls.
// Outside EXEC it emits the quiescent control word.
module uc_decode
   import microc_pkg::*;
(
   input  logic       exec,
   input  logic [5:0] ir,
   input  logic       zero,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = CTRL_IDLE;
      if (exec) begin
         ctrl.pc_en = 1'b1;
         if (!ir[5]) begin
            ctrl.alu_op = ir[4:2];
            ctrl.we     = 1'b1;
            ctrl.wez    = 1'b1;
         end else begin
            case (ir)
               OP_LI: begin
                  ctrl.s_inm = 1'b1;
                  ctrl.we    = 1'b1;
               end
               OP_J:    ctrl.s_inc = 1'b0;
               OP_JZ:   ctrl.s_inc = ~zero;
               OP_JNZ:  ctrl.s_inc = zero;
               OP_HALT: ctrl.pc_en = 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/uc_multicycle.sv
// Two-cycle (FETCH/EXEC) control unit with a halt state and a wrapping
// retired-instruction counter; controls are decoded from the latched IR.
module uc_multicycle
   import microc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  Opcode,
   input  logic        zero,
   output logic        s_inc,
   output logic        s_inm,
   output logic        we,
   output logic        wez,
   output logic [2:0]  AluOP,
   output logic        pc_en,
   output logic        halted,
   output logic [15:0] icount
);

   state_t      state;
   logic [5:0]  ir;
   logic [15:0] cnt;
   ctrl_t       ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         ir     <= 6'b000000;
         cnt    <= 16'h0000;
         halted <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) state <= S_FETCH;
            S_FETCH: begin
               ir    <= Opcode;
               state <= S_EXEC;
            end
            S_EXEC: begin
               cnt <= cnt + 16'd1;
               if (ir == OP_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Controls are combinational on state so reset forces them immediately.
   uc_decode u_decode (
      .exec (state == S_EXEC),
      .ir   (ir),
      .zero (zero),
      .ctrl (ctrl)
   );

   assign s_inc  = ctrl.s_inc;
   assign s_inm  = ctrl.s_inm;
   assign we     = ctrl.we;
   assign wez    = ctrl.wez;
   assign AluOP  = ctrl.alu_op;
   assign pc_en  = ctrl.pc_en;
   assign icount = cnt;

endmodule

// File: doc/uc_multicycle.md
UC_MULTICYCLE -- requirements
Module: uc_multicycle

Interface
REQ-001 The module SHALL expose: clk  input  1  system clock, rising-edge active.
REQ-002 The module SHALL expose: reset  input  1  asynchronous, active-high reset.
REQ-003 The module SHALL expose: start  input  1  leaves IDLE when high.
REQ-004 The module SHALL expose: Opcode  input  6  current instruction opcode from the datapath.
REQ-005 The module SHALL expose: zero  input  1  registered zero flag from the datapath.
REQ-006 The module SHALL expose: s_inc  output  1  PC source select; 1 = PC+1, 0 = jump target.
REQ-007 The module SHALL expose: s_inm  output  1  register-file write source; 1 = immediate, 0 = ALU.
REQ-008 The module SHALL expose: we  output  1  register-file write enable.
REQ-009 The module SHALL expose: wez  output  1  zero-flag write enable.
REQ-010 The module SHALL expose: AluOP  output  3  ALU operation.
REQ-011 The module SHALL expose: pc_en  output  1  PC load enable.
REQ-012 The module SHALL expose: halted  output  1  high while in HALT.
REQ-013 The module SHALL expose: icount  output  16  retired-instruction counter.

Function
REQ-014 The FSM SHALL have four states: IDLE, FETCH, EXEC, HALT.
REQ-015 IDLE SHALL go to FETCH on start=1 and otherwise stay in IDLE; start is ignored in every other state.
REQ-016 In FETCH the module SHALL latch Opcode into an internal 6-bit IR, drive we=wez=pc_en=0, and go to EXEC next cycle.
REQ-017 In EXEC the outputs SHALL be decoded combinationally from IR (not from live Opcode); the next state SHALL be FETCH, or HALT if IR=111111.
REQ-018 ALU op (IR[5]=0): AluOP=IR[4:2], s_inm=0, we=1, wez=1, s_inc=1, pc_en=1.
REQ-019 LI (IR=100000): s_inm=1, we=1, wez=0, s_inc=1, pc_en=1, AluOP=000.
REQ-020 J (IR=101000): s_inc=0, pc_en=1, we=0, wez=0.
REQ-021 JZ (IR=101001): s_inc=~zero, pc_en=1; zero is sampled in the EXEC cycle.
REQ-022 JNZ (IR=101010): s_inc=zero, pc_en=1.
REQ-023 HALT (IR=111111): pc_en=0, we=0, wez=0; next state HALT; halted=1 from the following cycle.
REQ-024 Any other IR SHALL act as a NOP: s_inc=1, pc_en=1, we=0, wez=0.
REQ-025 Outside EXEC the outputs SHALL be: s_inc=1, s_inm=0, we=0, wez=0, AluOP=000, pc_en=0.
REQ-026 icount SHALL increment by 1 at the end of every EXEC cycle, including HALT and NOP, and SHALL wrap from FFFF to 0000.
REQ-027 The module SHALL retire one instruction per 2 cycles, with no stalls.
REQ-028 HALT SHALL be left only by reset.

Reset
REQ-029 Reset assertion SHALL immediately force state=IDLE, IR=000000, icount=0, halted=0 and the REQ-025 output values, including when reset arrives mid-EXEC.
REQ-030 After reset release the module SHALL stay in IDLE until start=1 is sampled.

Structure
REQ-031 The state encoding and the opcode constants (OP_LI, OP_J, OP_JZ, OP_JNZ, OP_HALT) SHALL live in the shared package microc_pkg.
REQ-032 The module SHALL contain one sub-module, uc_decode, a combinational IR/zero-to-controls decoder instantiated inside uc_multicycle.

Verification
REQ-033 Scenario: reset pulse of 3 ns, start=0 for 5 cycles -> stays in IDLE; pc_en=0, we=0, icount=0.
REQ-034 Scenario: start=1, Opcode=100000 -> FETCH, then EXEC with s_inm=1, we=1, wez=0, pc_en=1; icount=1.
REQ-035 Scenario: Opcode=001000 (ADD) -> in EXEC AluOP=010, we=1, wez=1, s_inm=0, s_inc=1.
REQ-036 Scenario: JZ with zero=1, then JZ with zero=0 -> s_inc=0 in the first EXEC, s_inc=1 in the second.
REQ-037 Scenario: Opcode=111111 -> halted=1 after the EXEC cycle; pc_en=0 forever after; start toggling has no effect; reset returns to IDLE.
REQ-038 Scenario: preload 65535 retirements -> the next EXEC wraps icount to 0000.
